// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word and the memory-arbiter state encoding.
package cpu_types_pkg;

    localparam int unsigned WordW = 32;

    typedef logic [WordW-1:0] word_t;

    typedef enum logic [1:0] {
        StIdle,
        StDacc,
        StIacc,
        StTurn
    } arb_state_t;

endpackage

// File: rtl/arb_wdog.sv
// Access watchdog: counts RAM wait cycles and flags expiry on the last allowed cycle.
module arb_wdog #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic tick,
    output logic expire
);

    localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign expire = tick && (cnt_q == LastCnt);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_request_arbiter.sv
// Shares one single-ported RAM between instruction fetch and data load/store.
// Data wins over fetch; every access is followed by one bubble cycle.
module mem_request_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              ihit,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dhit,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ram_rdy,
    output logic              err
);

    arb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              wen_q, wen_d;
    logic              err_q, err_d;
    logic              wd_clr, wd_tick, wd_expire;

    assign err = err_q;

    arb_wdog #(
        .TIMEOUT(TIMEOUT)
    ) u_wdog (
        .CLK   (CLK),
        .RST   (RST),
        .clr   (wd_clr),
        .tick  (wd_tick),
        .expire(wd_expire)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        wen_d    = wen_q;
        err_d    = err_q;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        ihit     = 1'b0;
        iload    = '0;
        dhit     = 1'b0;
        dload    = '0;
        wd_clr   = 1'b1;
        wd_tick  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (dREN || dWEN) begin
                    state_d = StDacc;
                    addr_d  = daddr;
                    data_d  = dstore;
                    wen_d   = dWEN;
                end else if (iREN) begin
                    state_d = StIacc;
                    addr_d  = iaddr;
                    wen_d   = 1'b0;
                end
            end

            StDacc: begin
                wd_clr   = 1'b0;
                ramWEN   = wen_q;
                ramREN   = ~wen_q;
                ramaddr  = addr_q;
                ramstore = data_q;
                // A write captured with both enables high is withdrawn only by dWEN.
                if (wen_q ? !dWEN : !dREN) begin
                    state_d = StTurn;
                end else if (ram_rdy) begin
                    dhit    = 1'b1;
                    dload   = ramload;
                    state_d = StTurn;
                end else begin
                    wd_tick = 1'b1;
                    if (wd_expire) begin
                        err_d   = 1'b1;
                        state_d = StTurn;
                    end
                end
            end

            StIacc: begin
                wd_clr  = 1'b0;
                ramREN  = 1'b1;
                ramaddr = addr_q;
                if (!iREN) begin
                    state_d = StTurn;
                end else if (ram_rdy) begin
                    ihit    = 1'b1;
                    iload   = ramload;
                    state_d = StTurn;
                end else begin
                    wd_tick = 1'b1;
                    if (wd_expire) begin
                        err_d   = 1'b1;
                        state_d = StTurn;
                    end
                end
            end

            StTurn: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            addr_q  <= '0;
            data_q  <= '0;
            wen_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wen_q   <= wen_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Scoreboard bench: driver pushes expected responses, monitor pops on each hit or error.
module tb_mem_request_arbiter;

    localparam int TIMEOUT = 16;
    localparam int KFetch = 0, KRead = 1, KWrite = 2, KTimeout = 3;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
    logic [31:0] iaddr = '0, daddr = '0, dstore = '0;
    logic        ihit, dhit, ramREN, ramWEN, ram_rdy, err;
    logic [31:0] iload, dload, ramaddr, ramstore, ramload;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    logic [31:0] ram_arr[256];
    logic [31:0] ref_mem[256];
    logic        ram_init = 1'b1;
    int          ram_delay = 0;
    int          wait_cnt;

    mem_request_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .iREN    (iREN),
        .iaddr   (iaddr),
        .ihit    (ihit),
        .iload   (iload),
        .dREN    (dREN),
        .dWEN    (dWEN),
        .daddr   (daddr),
        .dstore  (dstore),
        .dhit    (dhit),
        .dload   (dload),
        .ramREN  (ramREN),
        .ramWEN  (ramWEN),
        .ramaddr (ramaddr),
        .ramstore(ramstore),
        .ramload (ramload),
        .ram_rdy (ram_rdy),
        .err     (err)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] pat(input int i);
        return 32'hC0DE_0000 ^ (i * 32'h0001_0101);
    endfunction

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endfunction

    // RAM model: completes an access once it has been enabled for ram_delay cycles.
    assign ram_rdy = (ramREN || ramWEN) && (wait_cnt == ram_delay);
    assign ramload = ram_arr[ramaddr[9:2]];

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            wait_cnt <= 0;
            if (ram_init) begin
                for (int i = 0; i < 256; i++) ram_arr[i] <= pat(i);
            end
        end else begin
            if ((ramREN || ramWEN) && !ram_rdy) wait_cnt <= wait_cnt + 1;
            else wait_cnt <= 0;
            if (ramWEN && ram_rdy) ram_arr[ramaddr[9:2]] <= ramstore;
        end
    end

    // Monitor
    int   cyc = 0, last_fall = -100;
    logic en_prev = 1'b0, ihit_prev = 1'b0, dhit_prev = 1'b0, err_prev = 1'b0;

    always begin
        logic en;
        exp_t e;
        int   got;
        @(negedge CLK);
        #2;
        cyc++;
        en = ramREN || ramWEN;
        if (en && !en_prev) check("access_spacing_ok", 32'(cyc - last_fall >= 2), 32'd1);
        if (!en && en_prev) last_fall = cyc;
        if (ihit || dhit) begin
            check("hit_exclusive_pulse",
                  32'((ihit && dhit) || (ihit && ihit_prev) || (dhit && dhit_prev)), 32'd0);
            got = ihit ? KFetch : (ramWEN ? KWrite : KRead);
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_hit: got hit kind %0d, want no response", got);
            end else begin
                e = sb.pop_front();
                check("hit_kind", 32'(got), 32'(e.kind));
                check("hit_ramaddr", ramaddr, e.addr);
                if (got == KFetch) check("iload", iload, e.data);
                else if (got == KRead) check("dload", dload, e.data);
                else check("ramstore", ramstore, e.data);
            end
        end
        if (err && !err_prev) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_err: got err rise, want no response");
            end else begin
                e = sb.pop_front();
                check("err_kind", KTimeout, 32'(e.kind));
            end
        end
        en_prev   = en;
        ihit_prev = ihit;
        dhit_prev = dhit;
        err_prev  = err;
    end

    // Issue one request set (optional fetch plus optional data op) and hold until served.
    task automatic run_txn(input bit fi, input bit fr, input bit fw, input logic [31:0] ia,
                           input logic [31:0] da, input logic [31:0] ds, input int dly);
        bit dp = fr || fw, ip = fi, dd = 1'b0, id = 1'b0;
        int n = 0;
        exp_t e;
        if (fw) begin
            ref_mem[da[9:2]] = ds;
            e = '{KWrite, da, ds};
            sb.push_back(e);
        end else if (fr) begin
            e = '{KRead, da, ref_mem[da[9:2]]};
            sb.push_back(e);
        end
        if (fi) begin
            e = '{KFetch, ia, ref_mem[ia[9:2]]};
            sb.push_back(e);
        end
        ram_delay = dly;
        iREN = fi; iaddr = ia; dREN = fr; dWEN = fw; daddr = da; dstore = ds;
        while ((dp || ip || dd || id) && n < 2 * (TIMEOUT + 5)) begin
            @(negedge CLK);
            n++;
            if (dd) begin dREN = 1'b0; dWEN = 1'b0; dd = 1'b0; end
            if (id) begin iREN = 1'b0; id = 1'b0; end
            if (dp && dhit) begin dp = 1'b0; dd = 1'b1; end
            if (ip && ihit) begin ip = 1'b0; id = 1'b1; end
        end
        if (dp || ip || dd || id) begin
            check("txn_completed_in_budget", 32'd0, 32'd1);
            iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
            sb.delete();
            repeat (3) @(negedge CLK);
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
        #1 RST = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        ram_init = 1'b0;
        #1;
        check("rst_ramREN", 32'(ramREN), 0);
        check("rst_ramWEN", 32'(ramWEN), 0);
        check("rst_ramaddr", ramaddr, 0);
        check("rst_ramstore", ramstore, 0);
        check("rst_hits", {ihit, dhit}, 0);
        check("rst_loads", iload | dload, 0);
        check("rst_err", 32'(err), 0);
        @(negedge CLK);

        // Fetch of a known instruction, RAM answers 2 cycles after enable.
        run_txn(0, 0, 1, '0, 32'h40, 32'h8C22_0004, 0);
        run_txn(1, 0, 0, 32'h40, '0, '0, 2);

        // Fetch and store together: store goes first, fetch follows after a bubble.
        run_txn(1, 0, 1, 32'h44, 32'h100, 32'hDEAD_BEEF, 1);
        run_txn(0, 1, 0, '0, 32'h100, '0, 0);

        // Both dREN and dWEN high is a write.
        run_txn(0, 1, 1, '0, 32'h104, 32'h1234_5678, 0);
        run_txn(0, 1, 0, '0, 32'h104, '0, 3);

        // ram_rdy on the last allowed wait cycle still hits.
        run_txn(0, 1, 0, '0, 32'h108, '0, TIMEOUT - 1);
        check("err_after_late_rdy", 32'(err), 0);

        // Withdrawn read: no hit, enables drop next cycle.
        ram_delay = 1000;
        dREN = 1'b1; daddr = 32'h20;
        @(negedge CLK);
        @(negedge CLK);
        dREN = 1'b0;
        #1 check("abort_no_dhit", 32'(dhit), 0);
        @(negedge CLK);
        check("abort_turn_enables", {ramREN, ramWEN}, 0);
        @(negedge CLK);
        check("abort_idle_enables", {ramREN, ramWEN}, 0);

        // Timeout: no ram_rdy ever.
        sb.push_back('{KTimeout, 32'h200, '0});
        dREN = 1'b1; daddr = 32'h200;
        n = 0;
        while (!err && n < 40) begin
            @(negedge CLK);
            n++;
        end
        check("timeout_cycles", 32'(n), 32'(TIMEOUT + 1));
        dREN = 1'b0;
        @(negedge CLK);
        check("timeout_idle_enables", {ramREN, ramWEN}, 0);
        check("timeout_err_sticky", 32'(err), 1);

        // Reset in the middle of a fetch.
        iREN = 1'b1; iaddr = 32'h80;
        n = 0;
        while (!ramREN && n < 5) begin
            @(negedge CLK);
            n++;
        end
        @(negedge CLK);
        check("iacc_ramREN", 32'(ramREN), 1);
        #1 RST = 1'b1;
        #1;
        check("rst_async_ramREN", 32'(ramREN), 0);
        check("rst_async_ihit", 32'(ihit), 0);
        iREN = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("rst2_enables", {ramREN, ramWEN}, 0);
        check("rst2_ramaddr", ramaddr, 0);
        check("rst2_hits", {ihit, dhit}, 0);
        check("rst2_err", 32'(err), 0);
        @(negedge CLK);
        run_txn(0, 1, 0, '0, 32'h100, '0, 0);

        // Randomized traffic.
        for (int t = 0; t < 150; t++) begin
            int          k, dly;
            bit          fw;
            logic [31:0] a1, a2, d;
            k  = int'($urandom_range(0, 4));
            a1 = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            a2 = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            d  = $urandom;
            dly = ($urandom_range(0, 7) == 0) ? TIMEOUT - 1 : int'($urandom_range(0, 5));
            fw = 1'($urandom_range(0, 1));
            case (k)
                0: run_txn(1, 0, 0, a1, '0, '0, dly);
                1: run_txn(0, 1, 0, '0, a2, '0, dly);
                2: run_txn(0, 0, 1, '0, a2, d, dly);
                3: run_txn(0, 1, 1, '0, a2, d, dly);
                default: run_txn(1, !fw, fw, a1, a2, d, dly);
            endcase
            repeat ($urandom_range(0, 2)) @(negedge CLK);
        end

        repeat (4) @(negedge CLK);
        check("scoreboard_drained", 32'(sb.size()), 0);
        check("final_err_clear", 32'(err), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
